// File: rtl/lfsr13.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr13
//  Purpose  : Seeded 13-bit maximal-length Fibonacci LFSR (x^13+x^4+x^3+x+1)
//             with an eight-entry seed table and a one-cycle period-wrap flag.
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr13 (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  seed_no,
    output logic [12:0] lfsr,
    output logic        lfsr_done
);

    localparam logic [12:0] c_SEED_0 = 13'h0001;
    localparam logic [12:0] c_SEED_1 = 13'h1ACE;
    localparam logic [12:0] c_SEED_2 = 13'h0B5D;
    localparam logic [12:0] c_SEED_3 = 13'h1234;
    localparam logic [12:0] c_SEED_4 = 13'h0F0F;
    localparam logic [12:0] c_SEED_5 = 13'h1555;
    localparam logic [12:0] c_SEED_6 = 13'h0AAA;
    localparam logic [12:0] c_SEED_7 = 13'h1FFF;

    logic [12:0] r_lfsr;
    logic [12:0] r_seed;
    logic        r_done;

    logic [12:0] w_seed;
    logic        w_fb;
    logic [12:0] w_next;
    logic        w_lockup;

    always_comb begin
        w_seed = c_SEED_0;
        case (seed_no)
            3'd0:    w_seed = c_SEED_0;
            3'd1:    w_seed = c_SEED_1;
            3'd2:    w_seed = c_SEED_2;
            3'd3:    w_seed = c_SEED_3;
            3'd4:    w_seed = c_SEED_4;
            3'd5:    w_seed = c_SEED_5;
            3'd6:    w_seed = c_SEED_6;
            default: w_seed = c_SEED_7;
        endcase
    end

    assign w_fb     = r_lfsr[12] ^ r_lfsr[3] ^ r_lfsr[2] ^ r_lfsr[0];
    assign w_lockup = (r_lfsr == 13'd0);
    // An all-zero state would stick forever; recover by reloading the seed.
    assign w_next   = w_lockup ? r_seed : {r_lfsr[11:0], w_fb};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= w_seed;
            r_seed <= w_seed;
            r_done <= 1'b0;
        end else begin
            r_lfsr <= w_next;
            r_done <= !w_lockup && (w_next == r_seed);
        end
    end

    assign lfsr      = r_lfsr;
    assign lfsr_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lfsr13.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr13
//  Purpose  : Self-checking bench for lfsr13: vector table, scoreboard queue
//             fed by a reference model, and long-run wrap/reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr13;

    logic        clk;
    logic        rst;
    logic [2:0]  seed_no;
    logic [12:0] lfsr;
    logic        lfsr_done;

    lfsr13 dut (
        .clk       (clk),
        .rst       (rst),
        .seed_no   (seed_no),
        .lfsr      (lfsr),
        .lfsr_done (lfsr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [2:0]  sn;
        logic [12:0] lfsr;
        logic        done;
    } vec_t;

    typedef struct packed {
        logic [12:0] lfsr;
        logic        done;
    } exp_t;

    exp_t        sb_q[$];
    logic [12:0] seeds[8];
    logic [12:0] m_lfsr;
    logic [12:0] m_seed;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [12:0] next13(input logic [12:0] s);
        return {s[11:0], s[12] ^ s[3] ^ s[2] ^ s[0]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, push the expectation, then compare what the DUT shows.
    task automatic step(input logic r, input logic [2:0] sn, input logic ovr,
                        input logic [12:0] el, input logic ed, input string name,
                        output logic [12:0] al, output logic ad);
        exp_t e;
        exp_t g;
        logic [12:0] nx;
        rst     = r;
        seed_no = sn;
        if (r) begin
            m_seed = seeds[sn];
            m_lfsr = m_seed;
            e.lfsr = m_seed;
            e.done = 1'b0;
        end else begin
            nx     = (m_lfsr == 13'd0) ? m_seed : next13(m_lfsr);
            e.done = (m_lfsr != 13'd0) && (nx == m_seed);
            e.lfsr = nx;
            m_lfsr = nx;
        end
        if (ovr) begin
            e.lfsr = el;
            e.done = ed;
        end
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        al = lfsr;
        ad = lfsr_done;
        if (sb_q.size() == 0) begin
            check({name, " queue"}, 0, 1);
        end else begin
            g = sb_q.pop_front();
            check({name, " lfsr"}, int'(al), int'(g.lfsr));
            check({name, " done"}, int'(ad), int'(g.done));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[13];
        logic [12:0] al;
        logic        ad;
        logic        seen[8192];
        int          ndist, nzero, nearly, npulse, ppos;

        seeds[0] = 13'h0001; seeds[1] = 13'h1ACE; seeds[2] = 13'h0B5D; seeds[3] = 13'h1234;
        seeds[4] = 13'h0F0F; seeds[5] = 13'h1555; seeds[6] = 13'h0AAA; seeds[7] = 13'h1FFF;

        vecs[0]  = '{1'b1, 3'd0, 13'h0001, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 13'h0003, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 13'h0007, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 13'h000E, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 13'h001C, 1'b0};
        vecs[5]  = '{1'b1, 3'd1, 13'h1ACE, 1'b0};
        vecs[6]  = '{1'b1, 3'd2, 13'h0B5D, 1'b0};
        vecs[7]  = '{1'b1, 3'd3, 13'h1234, 1'b0};
        vecs[8]  = '{1'b1, 3'd4, 13'h0F0F, 1'b0};
        vecs[9]  = '{1'b1, 3'd5, 13'h1555, 1'b0};
        vecs[10] = '{1'b1, 3'd6, 13'h0AAA, 1'b0};
        vecs[11] = '{1'b1, 3'd7, 13'h1FFF, 1'b0};
        vecs[12] = '{1'b1, 3'd0, 13'h0001, 1'b0};

        rst     = 1'b1;
        seed_no = 3'd0;
        m_lfsr  = 13'h0001;
        m_seed  = 13'h0001;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            step(vecs[i].rst, vecs[i].sn, 1'b1, vecs[i].lfsr, vecs[i].done,
                 $sformatf("vec%0d", i), al, ad);

        // Held reset keeps the seed and no pulse.
        step(1'b1, 3'd0, 1'b1, 13'h0001, 1'b0, "hold_rst", al, ad);

        // seed_no changes without reset must not disturb the running sequence.
        for (int i = 0; i < 10; i++)
            step(1'b0, 3'd5, 1'b0, 13'h0, 1'b0, "seedchg_run", al, ad);
        step(1'b1, 3'd5, 1'b1, 13'h1555, 1'b0, "seedchg_rst", al, ad);

        // Full period from seed 3.
        step(1'b1, 3'd3, 1'b1, 13'h1234, 1'b0, "p3_rst", al, ad);
        foreach (seen[i]) seen[i] = 1'b0;
        ndist = 0; nzero = 0; nearly = 0; npulse = 0; ppos = 0;
        for (int k = 1; k <= 8191; k++) begin
            step(1'b0, 3'd3, 1'b0, 13'h0, 1'b0, "p3_run", al, ad);
            if (al == 13'd0) nzero++;
            if (al == 13'h1234 && k != 8191) nearly++;
            if (!seen[al]) ndist++;
            seen[al] = 1'b1;
            if (ad) begin npulse++; ppos = k; end
        end
        check("p3_final_lfsr", int'(al), 32'h1234);
        check("p3_distinct", ndist, 8191);
        check("p3_zero", nzero, 0);
        check("p3_early_repeat", nearly, 0);
        check("p3_pulse_count", npulse, 1);
        check("p3_pulse_pos", ppos, 8191);

        // Reset held across the would-be wrap of seed 0.
        step(1'b1, 3'd0, 1'b1, 13'h0001, 1'b0, "w0_rst", al, ad);
        for (int k = 1; k <= 8190; k++)
            step(1'b0, 3'd0, 1'b0, 13'h0, 1'b0, "w0_run", al, ad);
        for (int k = 0; k < 3; k++)
            step(1'b1, 3'd0, 1'b1, 13'h0001, 1'b0, "w0_abort", al, ad);
        npulse = 0; ppos = 0;
        for (int k = 1; k <= 8191; k++) begin
            step(1'b0, 3'd0, 1'b0, 13'h0, 1'b0, "w0_restart", al, ad);
            if (ad) begin npulse++; ppos = k; end
        end
        check("w0_pulse_count", npulse, 1);
        check("w0_pulse_pos", ppos, 8191);

        // Lock-up recovery from a deposited all-zero state.
        step(1'b1, 3'd2, 1'b1, 13'h0B5D, 1'b0, "lk_rst", al, ad);
        for (int k = 0; k < 5; k++)
            step(1'b0, 3'd2, 1'b0, 13'h0, 1'b0, "lk_run", al, ad);
        force dut.r_lfsr = 13'd0;
        #1;
        release dut.r_lfsr;
        check("lk_deposit", int'(lfsr), 0);
        m_lfsr = 13'd0;
        step(1'b0, 3'd2, 1'b1, 13'h0B5D, 1'b0, "lk_recover", al, ad);
        step(1'b0, 3'd2, 1'b0, 13'h0, 1'b0, "lk_after", al, ad);

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
